// File: rtl/param_counter.sv
// rtl/param_counter.sv - modulo up/down counter with load, clear, wrap/saturate and event flags
// Count is always held in 0..MAX_VAL; limits are detected by compare, never by WIDTH overflow.
module param_counter #(
   parameter int WIDTH    = 4,
   parameter int MAX_VAL  = 2**WIDTH-1,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             event_p,
   output logic             ovf_sticky
);

   localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO  = '0;

   assign at_max = (count == LIMIT);
   assign at_min = (count == ZERO);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count      <= ZERO;
         event_p    <= 1'b0;
         ovf_sticky <= 1'b0;
      end else if (load) begin
         count   <= (load_value > LIMIT) ? LIMIT : load_value;
         event_p <= 1'b0;
      end else if (enable) begin
         if (up) begin
            if (at_max) begin
               count      <= SATURATE ? LIMIT : ZERO;
               event_p    <= 1'b1;
               ovf_sticky <= 1'b1;
            end else begin
               count   <= count + ONE;
               event_p <= 1'b0;
            end
         end else begin
            // Underflow mirrors overflow: wrap to the terminal value or hold at zero
            if (at_min) begin
               count      <= SATURATE ? ZERO : LIMIT;
               event_p    <= 1'b1;
               ovf_sticky <= 1'b1;
            end else begin
               count   <= count - ONE;
               event_p <= 1'b0;
            end
         end
      end else begin
         event_p <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - randomized and directed checks of wrap and saturate counters against a model
module tb_param_counter;

   localparam int MAXV = 9;

   logic       clk = 1'b0;
   logic       reset, enable, up, load, clear;
   logic [3:0] load_value;

   logic [3:0] count_w, count_s;
   logic       at_max_w, at_min_w, event_w, sticky_w;
   logic       at_max_s, at_min_s, event_s, sticky_s;

   int errors = 0;
   int checks = 0;

   int m_cnt[2];
   int m_ev[2];
   int m_st[2];

   always #5 clk = ~clk;

   param_counter #(.WIDTH(4), .MAX_VAL(MAXV), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_value(load_value), .clear(clear), .count(count_w), .at_max(at_max_w),
      .at_min(at_min_w), .event_p(event_w), .ovf_sticky(sticky_w)
   );

   param_counter #(.WIDTH(4), .MAX_VAL(MAXV), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_value(load_value), .clear(clear), .count(count_s), .at_max(at_max_s),
      .at_min(at_min_s), .event_p(event_s), .ovf_sticky(sticky_s)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: k=0 wraps, k=1 saturates; limits found by stepping past the legal range
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int nxt;
         if (reset || clear) begin
            m_cnt[k] = 0; m_ev[k] = 0; m_st[k] = 0;
         end else if (load) begin
            m_cnt[k] = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
            m_ev[k] = 0;
         end else if (enable) begin
            nxt = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
            if (nxt > MAXV || nxt < 0) begin
               if (k == 1) nxt = m_cnt[k];
               else nxt = (nxt > MAXV) ? 0 : MAXV;
               m_ev[k] = 1; m_st[k] = 1;
            end else begin
               m_ev[k] = 0;
            end
            m_cnt[k] = nxt;
         end else begin
            m_ev[k] = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("wrap.count",   int'(count_w),  m_cnt[0]);
      check("wrap.event",   int'(event_w),  m_ev[0]);
      check("wrap.sticky",  int'(sticky_w), m_st[0]);
      check("wrap.at_max",  int'(at_max_w), int'(m_cnt[0] == MAXV));
      check("wrap.at_min",  int'(at_min_w), int'(m_cnt[0] == 0));
      check("sat.count",    int'(count_s),  m_cnt[1]);
      check("sat.event",    int'(event_s),  m_ev[1]);
      check("sat.sticky",   int'(sticky_s), m_st[1]);
      check("sat.at_max",   int'(at_max_s), int'(m_cnt[1] == MAXV));
      check("sat.at_min",   int'(at_min_s), int'(m_cnt[1] == 0));
   endtask

   task automatic apply(input bit r, input bit c, input bit l, input int lv, input bit e, input bit u);
      reset = r; clear = c; load = l; load_value = 4'(lv); enable = e; up = u;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0; enable = 1'b0; up = 1'b0;
      m_cnt = '{0, 0}; m_ev = '{0, 0}; m_st = '{0, 0};
      #2;
      apply(1, 0, 0, 0, 0, 0);
      check("reset.count", int'(count_w), 0);

      // Count up through the wrap
      for (int i = 0; i < 12; i++) apply(0, 0, 0, 0, 1, 1);
      check("up12.count_wrap", int'(count_w), 2);
      check("up12.sticky", int'(sticky_w), 1);

      // Load 7 then step up four times
      apply(0, 0, 1, 7, 0, 0);
      for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 1, 1);
      check("sat.hold9", int'(count_s), 9);
      apply(0, 0, 0, 0, 0, 0);

      // Down from zero
      apply(0, 1, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 1, 0);
      check("down0.wrap", int'(count_w), 9);
      check("down0.sat", int'(count_s), 0);

      // Load clamp
      apply(0, 0, 1, 14, 0, 0);
      check("clamp", int'(count_w), 9);

      // Priority: clear over load over enable
      apply(0, 0, 1, 5, 0, 0);
      apply(0, 1, 1, 3, 1, 1);
      check("prio.clear", int'(count_w), 0);
      apply(0, 0, 1, 4, 1, 1);
      check("prio.load", int'(count_w), 4);

      // Reset mid-count with enable held
      apply(0, 0, 1, 6, 0, 0);
      apply(0, 0, 0, 0, 1, 0);
      apply(1, 0, 0, 0, 1, 1);
      apply(0, 0, 0, 0, 1, 1);
      check("resume", int'(count_w), 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit r, c, l, e, u;
         r = ($urandom_range(0, 49) == 0);
         c = ($urandom_range(0, 29) == 0);
         l = ($urandom_range(0, 9) == 0);
         e = ($urandom_range(0, 3) != 0);
         u = ($urandom_range(0, 2) != 0);
         apply(r, c, l, int'($urandom_range(0, 15)), e, u);
         if (event_w) check("inv.wrap_ev_sticky", int'(sticky_w), 1);
         if (event_s) check("inv.sat_ev_sticky", int'(sticky_s), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
